// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: NOP word, instruction width, opcode field, reset PC
package cpu_pkg;

    // Default instruction word width and the 6-bit opcode in its top bits.
    localparam int INS_W_DEF = 24;
    localparam int OP_W      = 6;
    localparam int OP_LSB    = INS_W_DEF - OP_W;

    // Width of PC, redirect target and jump-target field.
    localparam int PC_W = 16;

    // All-zero word is the NOP; its all-zero opcode is never a jump or return.
    localparam logic [INS_W_DEF-1:0] NOP_WORD = '0;
    localparam logic [OP_W-1:0]      OP_NOP   = '0;

    // PC loaded at reset unless the instantiation overrides it.
    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

    // Opcode field of a default-width instruction word.
    function automatic logic [OP_W-1:0] op_of(input logic [INS_W_DEF-1:0] word);
        return word[INS_W_DEF-1:OP_LSB];
    endfunction

    // Jump target field of a default-width instruction word.
    function automatic logic [PC_W-1:0] jmp_target_of(input logic [INS_W_DEF-1:0] word);
        return word[PC_W-1:0];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 1-write/1-read synchronous program RAM, read-before-write
module prog_mem #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port; contents are never cleared so a program survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; the non-blocking update gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - fetch PC, instruction register and redirect squash
module pc_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PM_AW    = 8,
    parameter int              INS_W    = INS_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_mux_sel,
    input  logic [PC_W-1:0]   jmp_loc,
    input  logic              pm_we,
    input  logic [PM_AW-1:0]  pm_waddr,
    input  logic [INS_W-1:0]  pm_wdata,
    output logic [INS_W-1:0]  ins,
    output logic [PC_W-1:0]   current_address,
    output logic              ins_valid,
    output logic [PC_W-1:0]   pc
);

    logic [PC_W-1:0]  pc_q,      pc_d;
    logic [PC_W-1:0]  cur_q,     cur_d;
    logic             valid_q,   valid_d;
    logic [PC_W-1:0]  pc_next;
    logic             fetch_en;
    logic [INS_W-1:0] pm_rdata;

    // The RAM output register is the data half of the IR, so it only advances
    // on the same cycles as the rest of the IR.
    assign fetch_en = ~stall & ~reset;

    prog_mem #(
        .AW (PM_AW),
        .DW (INS_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (pm_we),
        .waddr (pm_waddr),
        .wdata (pm_wdata),
        .re    (fetch_en),
        .raddr (pc_q[PM_AW-1:0]),
        .rdata (pm_rdata)
    );

    // Sequential successor or redirect target; 16-bit add wraps naturally.
    assign pc_next = pc_mux_sel ? jmp_loc : (pc_q + 16'd1);

    // Next state: reset beats stall, stall beats redirect; a redirect squashes
    // the word fetched this cycle.
    always_comb begin
        pc_d    = pc_q;
        cur_d   = cur_q;
        valid_d = valid_q;
        if (reset) begin
            pc_d    = RESET_PC;
            cur_d   = RESET_PC;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_next;
            cur_d   = pc_q;
            valid_d = ~pc_mux_sel;
        end
    end

    // PC and IR control registers.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        cur_q   <= cur_d;
        valid_q <= valid_d;
    end

    // A squashed or reset IR presents the all-zero NOP word.
    assign ins             = valid_q ? pm_rdata : '0;
    assign current_address = cur_q;
    assign ins_valid       = valid_q;
    assign pc              = pc_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        pm_we;
    logic [7:0]  pm_waddr;
    logic [23:0] pm_wdata;
    logic [23:0] ins;
    logic [15:0] current_address;
    logic        ins_valid;
    logic [15:0] pc;

    int passed;
    int total;

    pc_fetch_stage #(
        .PM_AW    (8),
        .INS_W    (24),
        .RESET_PC (16'h0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .pm_we           (pm_we),
        .pm_waddr        (pm_waddr),
        .pm_wdata        (pm_wdata),
        .ins             (ins),
        .current_address (current_address),
        .ins_valid       (ins_valid),
        .pc              (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] w(input int i);
        logic [7:0] a;
        a = i[7:0];
        return {8'h5A, a, ~a};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        stall      = 1'b1;
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0040;
        for (int i = 0; i < 256; i++) begin
            pm_we    = 1'b1;
            pm_waddr = i[7:0];
            pm_wdata = w(i);
            step();
        end
        pm_we = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {24'h0, 16'h0, 1'b0, 16'h0})
            $display("FAIL reset_state: ins=%h cur=%h valid=%b pc=%h, want 000000/0000/0/0000",
                     ins, current_address, ins_valid, pc);
        else passed++;
    endtask

    task automatic test_sequential();
        reset      = 1'b0;
        stall      = 1'b0;
        pc_mux_sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if ({ins, current_address, ins_valid, pc} !== {w(k), 16'(k), 1'b1, 16'(k + 1)})
                $display("FAIL seq_%0d: ins=%h cur=%h valid=%b pc=%h, want %h/%h/1/%h",
                         k, ins, current_address, ins_valid, pc, w(k), 16'(k), 16'(k + 1));
            else passed++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step(); step();
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0040;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {24'h0, 16'h0003, 1'b0, 16'h0040})
            $display("FAIL redirect_bubble: ins=%h cur=%h valid=%b pc=%h, want 000000/0003/0/0040",
                     ins, current_address, ins_valid, pc);
        else passed++;
        pc_mux_sel = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(8'h40), 16'h0040, 1'b1, 16'h0041})
            $display("FAIL redirect_target: ins=%h cur=%h valid=%b pc=%h, want %h/0040/1/0041",
                     ins, current_address, ins_valid, pc, w(8'h40));
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 6; k++) step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({ins, current_address, ins_valid, pc} !== {w(5), 16'h0005, 1'b1, 16'h0006})
                $display("FAIL stall_hold_%0d: ins=%h cur=%h valid=%b pc=%h, want %h/0005/1/0006",
                         k, ins, current_address, ins_valid, pc, w(5));
            else passed++;
        end
        stall = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(6), 16'h0006, 1'b1, 16'h0007})
            $display("FAIL stall_release: ins=%h cur=%h valid=%b pc=%h, want %h/0006/1/0007",
                     ins, current_address, ins_valid, pc, w(6));
        else passed++;
    endtask

    task automatic test_stall_redirect();
        stall      = 1'b1;
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0010;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({ins, current_address, ins_valid, pc} !== {w(6), 16'h0006, 1'b1, 16'h0007})
                $display("FAIL stall_over_redirect_%0d: ins=%h cur=%h valid=%b pc=%h, want %h/0006/1/0007",
                         k, ins, current_address, ins_valid, pc, w(6));
            else passed++;
        end
        stall = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {24'h0, 16'h0007, 1'b0, 16'h0010})
            $display("FAIL late_redirect_bubble: ins=%h cur=%h valid=%b pc=%h, want 000000/0007/0/0010",
                     ins, current_address, ins_valid, pc);
        else passed++;
        pc_mux_sel = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(8'h10), 16'h0010, 1'b1, 16'h0011})
            $display("FAIL late_redirect_target: ins=%h cur=%h valid=%b pc=%h, want %h/0010/1/0011",
                     ins, current_address, ins_valid, pc, w(8'h10));
        else passed++;
    endtask

    task automatic test_wrap();
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'hFFFF;
        step();
        pc_mux_sel = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(8'hFF), 16'hFFFF, 1'b1, 16'h0000})
            $display("FAIL wrap_ffff: ins=%h cur=%h valid=%b pc=%h, want %h/ffff/1/0000",
                     ins, current_address, ins_valid, pc, w(8'hFF));
        else passed++;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(0), 16'h0000, 1'b1, 16'h0001})
            $display("FAIL wrap_0000: ins=%h cur=%h valid=%b pc=%h, want %h/0000/1/0001",
                     ins, current_address, ins_valid, pc, w(0));
        else passed++;
    endtask

    task automatic test_read_before_write();
        step(); step();
        pm_we    = 1'b1;
        pm_waddr = 8'h03;
        pm_wdata = 24'hEEEEEE;
        step();
        pm_we = 1'b0;
        total++;
        if ({ins, current_address, ins_valid} !== {w(3), 16'h0003, 1'b1})
            $display("FAIL rbw_old: ins=%h cur=%h valid=%b, want %h/0003/1",
                     ins, current_address, ins_valid, w(3));
        else passed++;
        pc_mux_sel = 1'b1;
        jmp_loc    = 16'h0003;
        step();
        pc_mux_sel = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid} !== {24'hEEEEEE, 16'h0003, 1'b1})
            $display("FAIL rbw_new: ins=%h cur=%h valid=%b, want eeeeee/0003/1",
                     ins, current_address, ins_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_redirect();
        pc_mux_sel = 1'b1;
        stall      = 1'b1;
        jmp_loc    = 16'h0040;
        reset      = 1'b1;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {24'h0, 16'h0, 1'b0, 16'h0})
            $display("FAIL reset_mid: ins=%h cur=%h valid=%b pc=%h, want 000000/0000/0/0000",
                     ins, current_address, ins_valid, pc);
        else passed++;
        reset      = 1'b0;
        stall      = 1'b0;
        pc_mux_sel = 1'b0;
        step();
        total++;
        if ({ins, current_address, ins_valid, pc} !== {w(0), 16'h0, 1'b1, 16'h0001})
            $display("FAIL reset_release: ins=%h cur=%h valid=%b pc=%h, want %h/0000/1/0001",
                     ins, current_address, ins_valid, pc, w(0));
        else passed++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        pc_mux_sel = 1'b0;
        jmp_loc    = 16'h0;
        pm_we      = 1'b0;
        pm_waddr   = 8'h0;
        pm_wdata   = 24'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_wrap();
        test_read_before_write();
        test_reset_mid_redirect();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter PM_AW, default 8: program-memory address width; depth is 2^PM_AW words.
REQ-002 Parameter INS_W, default 24: instruction word width; op = ins[INS_W-1:INS_W-6], jump target = ins[15:0].
REQ-003 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hold PC and instruction register this cycle.
REQ-007 pc_mux_sel  in  1  redirect request from the jump control stage.
REQ-008 jmp_loc  in  16  redirect target PC.
REQ-009 pm_we  in  1  program-memory write enable (program load).
REQ-010 pm_waddr  in  PM_AW  program-memory write address.
REQ-011 pm_wdata  in  INS_W  program-memory write data.
REQ-012 ins  out  INS_W  registered instruction (IR) presented to decode and jump control.
REQ-013 current_address  out  16  PC of the instruction in IR.
REQ-014 ins_valid  out  1  IR holds a real, non-squashed instruction.
REQ-015 pc  out  16  fetch PC (address being read this cycle).

Function
REQ-016 The fetch PC register SHALL update every non-stalled cycle: pc <= pc_mux_sel ? jmp_loc : pc + 1, with 16-bit wrap (16'hFFFF + 1 = 16'h0000).
REQ-017 Program memory SHALL be read synchronously at index pc[PM_AW-1:0]; higher PC bits are ignored, so addresses alias modulo 2^PM_AW.
REQ-018 On a non-stalled cycle without redirect, IR SHALL load ins <= pm[pc], current_address <= pc, ins_valid <= 1.
REQ-019 On a non-stalled cycle with pc_mux_sel = 1, the wrong-path word fetched that cycle SHALL be squashed: ins <= NOP (all zeros), ins_valid <= 0, current_address <= pc; the target word appears in IR one cycle later.
REQ-020 Redirect-to-first-valid-target latency SHALL be 2 cycles: edge 1 loads pc = jmp_loc with a bubble in IR, edge 2 loads pm[jmp_loc] into IR with ins_valid = 1.
REQ-021 When stall = 1, pc, ins, current_address and ins_valid SHALL all hold their values.
REQ-022 stall SHALL take priority over pc_mux_sel; a redirect asserted while stalled takes effect on the first non-stalled cycle on which pc_mux_sel is still high.
REQ-023 Opcode all-zeros SHALL be the NOP encoding and SHALL never decode as a jump or return.
REQ-024 A pm_we write SHALL update pm[pm_waddr] at the clock edge, independent of stall and reset.
REQ-025 A read of the address being written in the same cycle SHALL return the old contents (read-before-write).
REQ-026 Interrupt vectoring is not handled here; it arrives only through jmp_loc and pc_mux_sel.

Reset
REQ-027 While reset = 1: pc = RESET_PC, ins = NOP, ins_valid = 0, current_address = RESET_PC; stall and pc_mux_sel are ignored.
REQ-028 Program-memory contents SHALL NOT be cleared by reset, so a program can be loaded while reset is held.
REQ-029 On the first edge after reset deasserts, IR SHALL load pm[RESET_PC] with ins_valid = 1, and pc SHALL become RESET_PC + 1.
REQ-030 Reset asserted mid-redirect or mid-stall SHALL discard the pending state, leaving the block exactly in the REQ-027 state.

Structure
REQ-031 A shared package (cpu_pkg) SHALL hold the NOP word, the INS_W default, the op field position and the RESET_PC default.
REQ-032 Program memory SHALL be a separate sub-module, prog_mem: a 1-write/1-read synchronous RAM with read-before-write behaviour.
REQ-033 PC update logic, IR register and squash logic SHALL reside in pc_fetch_stage.

Verification
REQ-034 Load pm[0..3] = A,B,C,D under reset, then release reset -> IR shows A,B,C,D on consecutive cycles, current_address = 0,1,2,3, and ins_valid = 1 throughout.
REQ-035 Assert pc_mux_sel for one cycle with jmp_loc = 16'h0040 while IR holds address 2 -> the next IR is NOP with ins_valid = 0, followed by pm[0x40] with current_address = 16'h0040.
REQ-036 Hold stall for 3 cycles with IR at address 5 -> ins, current_address and pc are unchanged for all 3 cycles; address 6 follows once stall drops.
REQ-037 Assert stall and pc_mux_sel together (jmp_loc = 16'h0010) for 2 cycles, then drop stall with pc_mux_sel held for 1 cycle -> the redirect occurs only after stall drops, and pm[0x10] appears 2 cycles later.
REQ-038 Redirect to jmp_loc = 16'hFFFF -> current_address reads FFFF then 0000, and the data returned is pm[FF] then pm[00] (PM_AW = 8).
REQ-039 Write pm[3] = E in the same cycle that pc = 3 -> IR receives the old pm[3]; a later refetch of address 3 returns E.
